// File: rtl/merge_pkg.sv
// Shared types and helpers for the merge scheduler: FSM state encoding,
// sentinel construction and the downstream bitonic merger latency.
package merge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MERGE   = 3'd1,
    ST_DRAIN_A = 3'd2,
    ST_DRAIN_B = 3'd3,
    ST_FLUSH   = 3'd4
  } state_e;

  localparam int DEFAULT_BUNDLE_WIDTH = 16;
  localparam int MERGE_LATENCY        = $clog2(DEFAULT_BUNDLE_WIDTH) + 1;

  function automatic int merge_latency(input int bundle_width);
    return $clog2(bundle_width) + 1;
  endfunction

  // One bit of the SENTINEL bundle: key bits of every element are ones, the rest zero.
  function automatic logic sentinel_bit(input int unsigned bit_pos,
                                        input int unsigned data_width,
                                        input int unsigned key_width);
    return (bit_pos % data_width) < key_width;
  endfunction

endpackage

// File: rtl/merge_credit_cnt.sv
// Saturating credit counter tracking free slots in the downstream output FIFO.
module merge_credit_cnt #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_consume,
  input  logic          i_return,
  output logic [CW-1:0] o_available
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= FULL;
    end else if (i_consume && !i_return) begin
      if (r_count != '0) r_count <= r_count - ONE;
    end else if (i_return && !i_consume) begin
      if (r_count != FULL) r_count <= r_count + ONE;
    end
  end

  assign o_available = r_count;

endmodule

// File: rtl/merge_scheduler.sv
// Chooses which sorted input bundle feeds the bitonic merger each cycle,
// pairing it with the previously issued bundle and closing each run with a sentinel flush.
module merge_scheduler
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int KEY_WIDTH    = 32,
  parameter int BUNDLE_WIDTH = 16,
  parameter int OUT_CREDITS  = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_a_valid,
  input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_a_bundle,
  input  logic                             i_a_last,
  input  logic                             i_b_valid,
  input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_b_bundle,
  input  logic                             i_b_last,
  output logic                             o_a_ready,
  output logic                             o_b_ready,
  output logic                             o_mrg_valid,
  output logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] o_mrg_bundle_0,
  output logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] o_mrg_bundle_1,
  output logic                             o_mrg_last,
  input  logic                             i_credit_return,
  output logic                             o_run_done,
  output logic                             o_busy
);

  localparam int BUS_W    = DATA_WIDTH * BUNDLE_WIDTH;
  localparam int CREDIT_W = $clog2(OUT_CREDITS + 1);

  logic [BUS_W-1:0]    w_sentinel;
  logic [CREDIT_W-1:0] w_credits;
  logic                w_has_credit;
  logic                w_sel_a;
  logic                w_issue;
  logic                w_flush;
  logic                w_a_ready;
  logic                w_b_ready;
  logic [BUS_W-1:0]    w_issue_bundle;
  state_e              w_next_state;

  state_e              r_state;
  logic [BUS_W-1:0]    r_hold;
  logic                r_mrg_valid;
  logic                r_mrg_last;
  logic                r_run_done;
  logic [BUS_W-1:0]    r_mrg_bundle_0;
  logic [BUS_W-1:0]    r_mrg_bundle_1;

  for (genvar gi = 0; gi < BUS_W; gi++) begin : g_sentinel
    assign w_sentinel[gi] = sentinel_bit(gi, DATA_WIDTH, KEY_WIDTH);
  end

  merge_credit_cnt #(
    .DEPTH(OUT_CREDITS)
  ) u_credit (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_consume   (w_issue),
    .i_return    (i_credit_return),
    .o_available (w_credits)
  );

  assign w_has_credit = (w_credits != '0);
  // Ties go to A so equal keys keep their A-before-B order.
  assign w_sel_a      = (i_a_bundle[KEY_WIDTH-1:0] <= i_b_bundle[KEY_WIDTH-1:0]);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_next_state   = r_state;
    w_issue        = 1'b0;
    w_flush        = 1'b0;
    w_a_ready      = 1'b0;
    w_b_ready      = 1'b0;
    w_issue_bundle = w_sentinel;
    case (r_state)
      ST_IDLE: begin
        if (i_a_valid || i_b_valid) w_next_state = ST_MERGE;
      end
      ST_MERGE: begin
        if (i_a_valid && i_b_valid && w_has_credit) begin
          w_issue = 1'b1;
          if (w_sel_a) begin
            w_a_ready      = 1'b1;
            w_issue_bundle = i_a_bundle;
            if (i_a_last) w_next_state = ST_DRAIN_B;
          end else begin
            w_b_ready      = 1'b1;
            w_issue_bundle = i_b_bundle;
            if (i_b_last) w_next_state = ST_DRAIN_A;
          end
        end
      end
      ST_DRAIN_A: begin
        if (i_a_valid && w_has_credit) begin
          w_issue        = 1'b1;
          w_a_ready      = 1'b1;
          w_issue_bundle = i_a_bundle;
          if (i_a_last) w_next_state = ST_FLUSH;
        end
      end
      ST_DRAIN_B: begin
        if (i_b_valid && w_has_credit) begin
          w_issue        = 1'b1;
          w_b_ready      = 1'b1;
          w_issue_bundle = i_b_bundle;
          if (i_b_last) w_next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_has_credit) begin
          w_issue      = 1'b1;
          w_flush      = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_hold         <= w_sentinel;
      r_mrg_valid    <= 1'b0;
      r_mrg_last     <= 1'b0;
      r_run_done     <= 1'b0;
      r_mrg_bundle_0 <= '0;
      r_mrg_bundle_1 <= '0;
    end else begin
      r_state     <= w_next_state;
      r_mrg_valid <= w_issue;
      r_mrg_last  <= w_flush;
      r_run_done  <= w_flush;
      if (w_issue) begin
        r_mrg_bundle_0 <= w_issue_bundle;
        r_mrg_bundle_1 <= r_hold;
      end
      if (r_state == ST_IDLE) r_hold <= w_sentinel;
      else if (w_issue)       r_hold <= w_issue_bundle;
    end
  end

  // Handshake outputs are masked during reset so no head is lost before the FSM settles.
  assign o_a_ready      = w_a_ready && !i_rst;
  assign o_b_ready      = w_b_ready && !i_rst;
  assign o_busy         = (r_state != ST_IDLE) && !i_rst;
  assign o_mrg_valid    = r_mrg_valid;
  assign o_mrg_last     = r_mrg_last;
  assign o_run_done     = r_run_done;
  assign o_mrg_bundle_0 = r_mrg_bundle_0;
  assign o_mrg_bundle_1 = r_mrg_bundle_1;

endmodule

// File: tb/tb_merge_scheduler.sv
// Randomized bench for merge_scheduler: streams are merged by a transaction-level
// model (merge order, hold chaining, sentinel flush, saturating credits) and compared every cycle.
module tb_merge_scheduler;

  localparam int DW  = 32;
  localparam int KW  = 32;
  localparam int BW  = 4;
  localparam int OC  = 2;
  localparam int BUS = DW * BW;

  typedef logic [BUS-1:0] bundle_t;
  typedef struct {
    bundle_t b0;
    bundle_t b1;
    logic    last;
  } issue_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_a_valid = 1'b0;
  bundle_t       i_a_bundle = '0;
  logic          i_a_last = 1'b0;
  logic          i_b_valid = 1'b0;
  bundle_t       i_b_bundle = '0;
  logic          i_b_last = 1'b0;
  logic          i_credit_return = 1'b0;
  logic          o_a_ready, o_b_ready, o_mrg_valid, o_mrg_last, o_run_done, o_busy;
  bundle_t       o_mrg_bundle_0, o_mrg_bundle_1;

  merge_scheduler #(
    .DATA_WIDTH(DW), .KEY_WIDTH(KW), .BUNDLE_WIDTH(BW), .OUT_CREDITS(OC)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .i_a_bundle(i_a_bundle), .i_a_last(i_a_last),
    .i_b_valid(i_b_valid), .i_b_bundle(i_b_bundle), .i_b_last(i_b_last),
    .o_a_ready(o_a_ready), .o_b_ready(o_b_ready),
    .o_mrg_valid(o_mrg_valid), .o_mrg_bundle_0(o_mrg_bundle_0),
    .o_mrg_bundle_1(o_mrg_bundle_1), .o_mrg_last(o_mrg_last),
    .i_credit_return(i_credit_return), .o_run_done(o_run_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  bundle_t a_run[$];
  bundle_t b_run[$];
  issue_t  exp_q[$];
  int      a_idx, b_idx;
  bit      a_fire, b_fire;
  int      m_cred;
  int      a_pct, b_pct, ret_pct;
  int      n_issues, n_done;
  int      n_checks, n_fail;

  task automatic check(input string name, input logic [BUS-1:0] got, input logic [BUS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bundle_t sentinel();
    bundle_t s;
    s = '0;
    for (int e = 0; e < BW; e++)
      for (int k = 0; k < KW; k++) s[e*DW + k] = 1'b1;
    return s;
  endfunction

  function automatic logic [KW-1:0] key0(input bundle_t b);
    return b[KW-1:0];
  endfunction

  function automatic bundle_t pack4(input int e0, input int e1, input int e2, input int e3);
    return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endfunction

  // Sorted stream: every element non-decreasing across the whole run.
  task automatic gen_stream(input int n, input int base, output bundle_t q[$]);
    int k;
    bundle_t b;
    q.delete();
    k = base;
    for (int i = 0; i < n; i++) begin
      for (int e = 0; e < BW; e++) begin
        k += $urandom_range(0, 6);
        b[e*DW +: DW] = DW'(k);
      end
      q.push_back(b);
    end
  endtask

  // Two-way merge by head key (ties to A), rest of the other run after a last,
  // then a sentinel flush; each issue carries the previous issue as its hold.
  task automatic build_expected();
    bundle_t hold;
    int i, j;
    bit done;
    hold = sentinel();
    i = 0; j = 0; done = 0;
    while (!done) begin
      if (key0(a_run[i]) <= key0(b_run[j])) begin
        exp_q.push_back('{b0: a_run[i], b1: hold, last: 1'b0});
        hold = a_run[i];
        if (i == a_run.size() - 1) begin
          for (int k = j; k < b_run.size(); k++) begin
            exp_q.push_back('{b0: b_run[k], b1: hold, last: 1'b0});
            hold = b_run[k];
          end
          done = 1;
        end
        i++;
      end else begin
        exp_q.push_back('{b0: b_run[j], b1: hold, last: 1'b0});
        hold = b_run[j];
        if (j == b_run.size() - 1) begin
          for (int k = i; k < a_run.size(); k++) begin
            exp_q.push_back('{b0: a_run[k], b1: hold, last: 1'b0});
            hold = a_run[k];
          end
          done = 1;
        end
        j++;
      end
    end
    exp_q.push_back('{b0: sentinel(), b1: hold, last: 1'b1});
  endtask

  // Compares what the previous rising edge produced against the model.
  task automatic observe();
    issue_t e;
    if (a_fire || b_fire) check("valid_after_handshake", o_mrg_valid, 1'b1);
    if (o_mrg_valid) begin
      n_issues++;
      check("credit_before_issue", m_cred > 0, 1'b1);
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("bundle_0", o_mrg_bundle_0, e.b0);
        check("bundle_1", o_mrg_bundle_1, e.b1);
        check("mrg_last", o_mrg_last, e.last);
        check("run_done", o_run_done, e.last);
      end
    end else begin
      check("run_done_no_issue", o_run_done, 1'b0);
    end
    if (o_run_done) begin
      n_done++;
      check("busy_after_flush", o_busy, 1'b0);
    end
    if (o_mrg_valid && !i_credit_return) m_cred = (m_cred > 0) ? m_cred - 1 : 0;
    else if (!o_mrg_valid && i_credit_return) m_cred = (m_cred < OC) ? m_cred + 1 : OC;
    check("credit_count", dut.u_credit.o_available, m_cred);
  endtask

  task automatic step();
    @(negedge i_clk);
    observe();
    if (a_fire) a_idx++;
    if (b_fire) b_idx++;
    i_a_valid       = (a_idx < a_run.size()) && ($urandom_range(0, 99) < a_pct);
    i_a_bundle      = (a_idx < a_run.size()) ? a_run[a_idx] : '0;
    i_a_last        = (a_idx == a_run.size() - 1);
    i_b_valid       = (b_idx < b_run.size()) && ($urandom_range(0, 99) < b_pct);
    i_b_bundle      = (b_idx < b_run.size()) ? b_run[b_idx] : '0;
    i_b_last        = (b_idx == b_run.size() - 1);
    i_credit_return = ($urandom_range(0, 99) < ret_pct);
    #1;
    a_fire = i_a_valid && o_a_ready;
    b_fire = i_b_valid && o_b_ready;
    if (a_fire && b_fire) check("both_ready", 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_credit_return = 1'b0;
    #1;
    check("rst_during_a_ready", o_a_ready, 1'b0);
    check("rst_during_b_ready", o_b_ready, 1'b0);
    check("rst_during_busy", o_busy, 1'b0);
    @(negedge i_clk);
    check("rst_mrg_valid", o_mrg_valid, 1'b0);
    check("rst_mrg_last", o_mrg_last, 1'b0);
    check("rst_run_done", o_run_done, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_bundle_0", o_mrg_bundle_0, '0);
    check("rst_bundle_1", o_mrg_bundle_1, '0);
    check("rst_credits", dut.u_credit.o_available, OC);
    i_rst = 1'b0;
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    a_run.delete(); b_run.delete(); exp_q.delete();
    a_idx = 0; b_idx = 0; a_fire = 0; b_fire = 0;
    m_cred = OC;
  endtask

  task automatic start_run();
    a_idx = 0; b_idx = 0; a_fire = 0; b_fire = 0;
    build_expected();
  endtask

  task automatic finish_run(input int budget);
    int done0;
    done0 = n_done;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) step();
    check("run_complete_remaining", exp_q.size(), 0);
    check("run_done_pulses", n_done - done0, 1);
    a_run.delete(); b_run.delete();
    a_idx = 0; b_idx = 0;
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i0;
    n_checks = 0; n_fail = 0; n_issues = 0; n_done = 0;
    a_pct = 100; b_pct = 100; ret_pct = 100;
    do_reset();

    // Interleaved single-bundle runs; hand-computed order pins the model.
    a_run.push_back(pack4(1, 3, 5, 7));
    b_run.push_back(pack4(2, 4, 6, 8));
    start_run();
    check("model_len", exp_q.size(), 3);
    check("model_first_b0", exp_q[0].b0, pack4(1, 3, 5, 7));
    check("model_first_b1", exp_q[0].b1, {BUS{1'b1}});
    check("model_second_b0", exp_q[1].b0, pack4(2, 4, 6, 8));
    check("model_third_last", exp_q[2].last, 1'b1);
    i0 = n_issues;
    finish_run(200);
    check("issue_count_1p1", n_issues - i0, 3);

    // Equal head keys select A.
    a_run.push_back(pack4(9, 10, 11, 12));
    b_run.push_back(pack4(9, 9, 9, 9));
    start_run();
    check("tie_model_b0", exp_q[0].b0, pack4(9, 10, 11, 12));
    check("tie_model_b1", exp_q[0].b1, {BUS{1'b1}});
    finish_run(200);

    // Saturation: returns while already full.
    ret_pct = 100;
    for (int c = 0; c < 4; c++) step();

    // Credit starvation: two issues, stall, then exactly one more per return.
    ret_pct = 0;
    gen_stream(3, 0, a_run);
    gen_stream(3, 2, b_run);
    start_run();
    i0 = n_issues;
    for (int c = 0; c < 20; c++) step();
    check("stall_issues", n_issues - i0, 2);
    ret_pct = 100;
    step();
    ret_pct = 0;
    for (int c = 0; c < 20; c++) step();
    check("one_return_issues", n_issues - i0, 3);
    ret_pct = 100;
    finish_run(400);

    // Only A valid in MERGE: no issues, no ready.
    a_pct = 100; b_pct = 0;
    gen_stream(2, 0, a_run);
    gen_stream(2, 0, b_run);
    start_run();
    step();
    i0 = n_issues;
    for (int c = 0; c < 10; c++) begin
      step();
      check("a_only_ready", o_a_ready, 1'b0);
    end
    check("a_only_issues", n_issues - i0, 0);
    b_pct = 100;
    finish_run(400);

    // Reset in DRAIN_A with zero credits, then a fresh run gets exactly two credits.
    ret_pct = 0;
    gen_stream(3, 1000, a_run);
    gen_stream(1, 0, b_run);
    start_run();
    for (int c = 0; c < 8; c++) step();
    check("pre_reset_busy", o_busy, 1'b1);
    check("pre_reset_credits", m_cred, 0);
    do_reset();
    gen_stream(3, 0, a_run);
    gen_stream(3, 0, b_run);
    start_run();
    i0 = n_issues;
    for (int c = 0; c < 20; c++) step();
    check("post_reset_issues", n_issues - i0, 2);
    ret_pct = 100;
    finish_run(400);

    // Randomized runs with random valid gaps and credit returns.
    for (int r = 0; r < 30; r++) begin
      a_pct   = $urandom_range(30, 100);
      b_pct   = $urandom_range(30, 100);
      ret_pct = $urandom_range(20, 100);
      gen_stream($urandom_range(1, 5), $urandom_range(0, 20), a_run);
      gen_stream($urandom_range(1, 5), $urandom_range(0, 20), b_run);
      start_run();
      finish_run(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_scheduler.md
MERGE_SCHEDULER -- requirements
Module: merge_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per element.
REQ-002 SHALL have parameter KEY_WIDTH, default 32, sort key width; key = element[KEY_WIDTH-1:0], ascending order.
REQ-003 SHALL have parameter BUNDLE_WIDTH, default 16, elements per bundle, power of two.
REQ-004 SHALL have parameter OUT_CREDITS, default 8, downstream output-FIFO depth in bundles.
REQ-005 i_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_a_valid / i_b_valid  in  1  head of sorted input stream A / B is valid.
REQ-008 i_a_bundle / i_b_bundle  in  DATA_WIDTH*BUNDLE_WIDTH  head bundle, internally sorted ascending, element 0 at LSBs.
REQ-009 i_a_last / i_b_last  in  1  head bundle is the final bundle of its run.
REQ-010 o_a_ready / o_b_ready  out  1  head consumed this cycle (valid && ready); may depend combinationally on valids.
REQ-011 o_mrg_valid  out  1  issue strobe to the lower-half bitonic merger.
REQ-012 o_mrg_bundle_0 / o_mrg_bundle_1  out  DATA_WIDTH*BUNDLE_WIDTH  new bundle / hold bundle to merger.
REQ-013 o_mrg_last  out  1  sideband, marks the final issue of a run.
REQ-014 i_credit_return  in  1  one bundle popped from the output FIFO.
REQ-015 o_run_done  out  1  one-cycle pulse after the final issue of a run.
REQ-016 o_busy  out  1  high in any state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, MERGE, DRAIN_A, DRAIN_B, FLUSH.
REQ-018 IDLE: hold register loads SENTINEL (every element key all-ones, non-key bits zero); go to MERGE when i_a_valid or i_b_valid.
REQ-019 Issue allowed only when credit count > 0; no issue in IDLE.
REQ-020 MERGE: issue only if both valids are high; select A if key(A elem0) <= key(B elem0), else B; tie selects A.
REQ-021 MERGE with one or both valids low: no issue, no ready, state unchanged.
REQ-022 On issue: o_mrg_bundle_0 = selected head, o_mrg_bundle_1 = hold register, hold register <= selected head, selected ready = 1 in the same cycle.
REQ-023 MERGE: selected head with last=1 -> DRAIN of the other stream (A last -> DRAIN_B, B last -> DRAIN_A).
REQ-024 DRAIN_x: issue stream x heads when valid and credit available; issuing x head with last=1 -> FLUSH.
REQ-025 FLUSH: when credit available, issue bundle_0 = SENTINEL, bundle_1 = hold, o_mrg_last = 1, go to IDLE; never assert either ready.
REQ-026 o_mrg_valid/bundles/last SHALL be registered: one cycle from handshake to o_mrg_valid; o_mrg_valid deasserted on cycles with no issue.
REQ-027 o_run_done SHALL pulse exactly one cycle, the cycle after FLUSH issue (coincides with FLUSH's o_mrg_valid).
REQ-028 Credit counter width $clog2(OUT_CREDITS+1); issue decrements, i_credit_return increments; both same cycle -> unchanged.
REQ-029 i_credit_return with counter at OUT_CREDITS SHALL saturate (no wrap); counter never underflows.
REQ-030 Full run of n_A + n_B bundles SHALL produce exactly n_A + n_B + 1 issues.

Reset
REQ-031 i_rst SHALL, in any state including mid-run, force IDLE, credits = OUT_CREDITS, hold = SENTINEL.
REQ-032 During and after reset: o_mrg_valid, o_mrg_last, o_run_done, o_a_ready, o_b_ready, o_busy = 0; o_mrg_bundle_0/1 = 0.

Structure
REQ-033 Shared package merge_pkg SHALL hold the FSM state enum, the SENTINEL construction function, and MERGE_LATENCY = log2(BUNDLE_WIDTH)+1.
REQ-034 Credit counter SHALL be a sub-module merge_credit_cnt (parameter DEPTH; inputs consume, return; output available).
REQ-035 Merger datapath SHALL remain outside this block; no stall into it.

Verification (BUNDLE_WIDTH=4, KEY=DATA=32, OUT_CREDITS=2)
REQ-036 A={1,3,5,7}last, B={2,4,6,8}last, credits returned every cycle -> A issued, then B, then FLUSH; o_mrg_last on 3rd issue; o_run_done one pulse.
REQ-037 Both heads elem0 key = 9 -> A selected; bundle_1 of first issue = SENTINEL.
REQ-038 No credit return, 3 bundles per stream -> exactly 2 issues, then stall; one i_credit_return -> exactly one more issue.
REQ-039 A only valid (B valid low) in MERGE for 10 cycles -> zero issues, o_a_ready low throughout.
REQ-040 i_rst asserted in DRAIN_A with credits = 0 -> next cycle IDLE, all outputs 0, credits = 2, o_busy = 0.
REQ-041 i_credit_return and issue same cycle at credits = 1 -> credits remain 1; extra return at 2 -> stays 2.
